// File: rtl/ddfs_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// ddfs_sweep_ctrl_if
// Bundles the chirp sequencer's control, configuration and DDFS-facing
// outputs.
//   master : register bank / stimulus side. Drives start/stop/repeat_en and
//            the configuration words, and observes fccw/env/busy/done_tick.
//   slave  : the sequencer itself. Receives control and configuration, and
//            drives fccw/env/busy/done_tick.
// ---------------------------------------------------------------------------
interface ddfs_sweep_ctrl_if #(
    parameter int FW = 26,
    parameter int EW = 16,
    parameter int CW = 24
);
    logic          start;
    logic          stop;
    logic          repeat_en;
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [CW-1:0] dwell;
    logic [EW-1:0] env_step;
    logic [EW-1:0] env_max;
    logic [FW-1:0] fccw;
    logic [EW-1:0] env;
    logic          busy;
    logic          done_tick;

    modport master (
        output start, stop, repeat_en, f_start, f_stop, f_step, dwell,
               env_step, env_max,
        input  fccw, env, busy, done_tick
    );

    modport slave (
        input  start, stop, repeat_en, f_start, f_stop, f_step, dwell,
               env_step, env_max,
        output fccw, env, busy, done_tick
    );
endinterface

// File: rtl/ddfs_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// ddfs_sweep_ctrl
// Drives the DDFS carrier word (fccw) and envelope word (env) through an
// attack / linear sweep / release sequence, optionally repeating.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset (aborts any phase)
//   bus    : slave modport of ddfs_sweep_ctrl_if
//            in : start, stop, repeat_en, f_start, f_stop, f_step, dwell,
//                 env_step, env_max
//            out: fccw, env, busy, done_tick (all registered)
// ---------------------------------------------------------------------------
module ddfs_sweep_ctrl #(
    parameter int FW = 26,
    parameter int EW = 16,
    parameter int CW = 24
) (
    input  logic               clk,
    input  logic               reset,
    ddfs_sweep_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SWEEP   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t        state_r, state_nx_s;
    logic [CW-1:0] cnt_r;
    logic          tick_s;

    // Configuration captured when start is accepted
    logic [FW-1:0] f_start_r, f_stop_r, f_step_r;
    logic [CW-1:0] dwell_r;
    logic [EW-1:0] env_step_r, env_max_r;
    logic          stopped_r;   // sequence was cut short: no repeat allowed

    logic [FW-1:0] fccw_r, fccw_nx_s;
    logic [EW-1:0] env_r, env_nx_s;
    logic          busy_r, busy_nx_s;
    logic          done_r, done_nx_s;

    // One extra bit on the sums so saturation decisions never see a wrap
    logic [EW:0]   env_sum_s;
    logic [FW:0]   f_sum_s;
    logic          attack_full_s, sweep_end_s, release_zero_s;
    logic [EW-1:0] env_up_s, env_dn_s;

    logic          start_ok_s;
    logic          stop_ok_s;

    assign start_ok_s = (state_r == ST_IDLE) && bus.start;
    assign stop_ok_s  = ((state_r == ST_ATTACK) || (state_r == ST_SWEEP)) && bus.stop;
    assign tick_s     = (cnt_r == dwell_r);

    // Saturating envelope / frequency arithmetic for the current tick
    always_comb begin
        env_sum_s      = {1'b0, env_r} + {1'b0, env_step_r};
        attack_full_s  = (env_step_r == {EW{1'b0}}) || (env_sum_s >= {1'b0, env_max_r});
        env_up_s       = attack_full_s ? env_max_r : env_sum_s[EW-1:0];
        release_zero_s = (env_step_r == {EW{1'b0}}) || (env_r <= env_step_r);
        env_dn_s       = release_zero_s ? {EW{1'b0}} : (env_r - env_step_r);
        f_sum_s        = {1'b0, fccw_r} + {1'b0, f_step_r};
        sweep_end_s    = (f_sum_s >= {1'b0, f_stop_r});
    end

    // State register and dwell counter (counter restarts on every state entry)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if ((state_nx_s != state_r) || tick_s || (state_r == ST_IDLE)) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state logic; stop outranks a phase-ending tick
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nx_s = ST_ATTACK;
                else           state_nx_s = ST_IDLE;
            end
            ST_ATTACK: begin
                if (bus.stop)                    state_nx_s = ST_RELEASE;
                else if (tick_s && attack_full_s) state_nx_s = ST_SWEEP;
                else                              state_nx_s = ST_ATTACK;
            end
            ST_SWEEP: begin
                if (bus.stop)                   state_nx_s = ST_RELEASE;
                else if (tick_s && sweep_end_s) state_nx_s = ST_RELEASE;
                else                            state_nx_s = ST_SWEEP;
            end
            ST_RELEASE: begin
                if (tick_s && release_zero_s) begin
                    if (bus.repeat_en && !stopped_r) state_nx_s = ST_ATTACK;
                    else                             state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RELEASE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        fccw_nx_s = fccw_r;
        env_nx_s  = env_r;
        done_nx_s = 1'b0;
        busy_nx_s = (state_nx_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    fccw_nx_s = bus.f_start;
                    env_nx_s  = {EW{1'b0}};
                end else begin
                    fccw_nx_s = fccw_r;
                end
            end
            ST_ATTACK: begin
                if (!bus.stop && tick_s) env_nx_s = env_up_s;
                else                     env_nx_s = env_r;
            end
            ST_SWEEP: begin
                if (!bus.stop && tick_s) fccw_nx_s = sweep_end_s ? f_stop_r : f_sum_s[FW-1:0];
                else                     fccw_nx_s = fccw_r;
            end
            ST_RELEASE: begin
                if (tick_s) begin
                    env_nx_s = env_dn_s;
                    if (release_zero_s) begin
                        if (bus.repeat_en && !stopped_r) fccw_nx_s = f_start_r;
                        else                             done_nx_s = 1'b1;
                    end else begin
                        done_nx_s = 1'b0;
                    end
                end else begin
                    env_nx_s = env_r;
                end
            end
            default: begin
                fccw_nx_s = fccw_r;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fccw_r <= {FW{1'b0}};
            env_r  <= {EW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            fccw_r <= fccw_nx_s;
            env_r  <= env_nx_s;
            busy_r <= busy_nx_s;
            done_r <= done_nx_s;
        end
    end

    // Configuration latch and early-stop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            f_start_r  <= {FW{1'b0}};
            f_stop_r   <= {FW{1'b0}};
            f_step_r   <= {FW{1'b0}};
            dwell_r    <= {CW{1'b0}};
            env_step_r <= {EW{1'b0}};
            env_max_r  <= {EW{1'b0}};
            stopped_r  <= 1'b0;
        end else if (start_ok_s) begin
            f_start_r  <= bus.f_start;
            f_stop_r   <= bus.f_stop;
            f_step_r   <= bus.f_step;
            dwell_r    <= bus.dwell;
            env_step_r <= bus.env_step;
            env_max_r  <= bus.env_max;
            stopped_r  <= 1'b0;
        end else if (stop_ok_s) begin
            stopped_r  <= 1'b1;
        end else begin
            stopped_r  <= stopped_r;
        end
    end

    assign bus.fccw      = fccw_r;
    assign bus.env       = env_r;
    assign bus.busy      = busy_r;
    assign bus.done_tick = done_r;

endmodule

// File: doc/ddfs_sweep_ctrl.md
Name: ddfs_sweep_ctrl

Overview:
- Sequencer that drives the DDFS carrier-frequency word and envelope word so the core produces a shaped chirp without CPU intervention.
- Runs a four-phase sequence: attack (envelope ramp-up at start frequency), linear frequency sweep, release (envelope ramp-down), then idle or repeat.
- Sits between the Avalon register bank, which supplies the configuration and start/stop pulses, and the DDFS core's fccw/env inputs.
- focw and pha are not touched by this block.

Parameters:
- FW, 26, frequency control word width.
- EW, 16, envelope word width (signed Q1.15, non-negative values only).
- CW, 24, dwell counter width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sequence when idle.
- stop  input  1  one-cycle pulse; forces an early release.
- repeat_en  input  1  restart at attack after release completes.
- f_start  input  FW  sweep start frequency word.
- f_stop  input  FW  sweep end frequency word.
- f_step  input  FW  frequency increment per tick.
- dwell  input  CW  tick period minus 1, in clk cycles.
- env_step  input  EW  envelope increment/decrement per tick.
- env_max  input  EW  envelope plateau value.
- fccw  output  FW  carrier frequency word to the DDFS core.
- env  output  EW  envelope word to the DDFS core.
- busy  output  1  high in any state other than IDLE.
- done_tick  output  1  one-cycle pulse when a sequence ends in IDLE.

Behaviour:
- Reset (synchronous, highest priority; aborts any phase immediately):
  - state=IDLE, fccw=0, env=0, busy=0, done_tick=0, tick counter=0.
- Configuration latch:
  - All config inputs are latched on the cycle start is accepted.
  - Input changes during a sequence have no effect until the next accepted start.
  - repeat_en is the exception: it is sampled live at the end of each release.
- Tick counter:
  - Resets to 0 on every state entry.
  - Increments each cycle; a tick fires when count == dwell, and the counter then returns to 0.
  - The first update in a state is visible dwell+1 cycles after entry; dwell=0 gives a tick every cycle.
- All outputs are registered.

States and transitions:
- IDLE
  - Outputs hold their last values.
  - start=1 in cycle N -> ATTACK visible at N+1 with fccw=f_start, env=0, busy=1.
  - stop is ignored.
- ATTACK
  - On each tick: env = min(env + env_step, env_max). The sum is computed at EW+1 bits, so there is no wraparound.
  - When the updated env equals env_max, go to SWEEP.
  - env_step=0: the first tick sets env=env_max.
- SWEEP
  - On each tick: if fccw + f_step >= f_stop (FW+1-bit compare), set fccw=f_stop and go to RELEASE; otherwise fccw += f_step.
  - f_start >= f_stop: the first tick sets fccw=f_stop and goes to RELEASE.
  - f_step=0 with f_start < f_stop: hold until stop.
- RELEASE
  - On each tick: env = max(env - env_step, 0), saturating at 0.
  - env_step=0: the first tick sets env=0.
  - When env reaches 0:
    - repeat_en=1: go to ATTACK with fccw=f_start and env=0; no done_tick.
    - repeat_en=0: go to IDLE and pulse done_tick for 1 cycle.
- stop pulse:
  - In ATTACK or SWEEP: go to RELEASE next cycle, with env and fccw held at their current values.
  - In RELEASE: ignored.
  - A stop that causes an exit suppresses repeat; the sequence ends in IDLE with done_tick.
- start outside IDLE is ignored.
- start and stop in the same IDLE cycle: start wins.
- stop and a state-ending tick in the same cycle: stop wins (ATTACK/SWEEP -> RELEASE).

Test Plan:
- Nominal chirp:
  - Stimulus: f_start=100, f_stop=130, f_step=10, dwell=2, env_step=0x4000, env_max=0x7FFF, repeat_en=0; start pulse.
  - Required: env 0x4000 then 0x7FFF at 3-cycle spacing; fccw 110, 120, 130; env 0x3FFF then 0; done_tick once; busy low after.
- Saturation and underflow:
  - Stimulus: env_step=0xFFFF, env_max=0x1234.
  - Required: env jumps 0 -> 0x1234 on the first attack tick and 0x1234 -> 0 on the first release tick, never wrapping.
- Early stop:
  - Stimulus: stop pulse mid-SWEEP while fccw=120.
  - Required: fccw holds 120; release runs to 0; done_tick fires even with repeat_en=1.
- Repeat mode:
  - Stimulus: repeat_en=1, nominal config.
  - Required: after env reaches 0, next cycle state=ATTACK with fccw=100; no done_tick. Clearing repeat_en -> next release ends in IDLE with done_tick.
- Degenerate configs:
  - Stimulus: f_start=200, f_stop=50.
  - Required: first sweep tick gives fccw=50, then RELEASE.
  - Stimulus: dwell=0.
  - Required: updates every cycle.
  - Stimulus: f_step=0.
  - Required: sweep holds until stop.
- Reset and ignored start:
  - Stimulus: synchronous reset asserted mid-ATTACK.
  - Required: next cycle fccw=0, env=0, busy=0, no done_tick.
  - Stimulus: start pulse during SWEEP.
  - Required: no effect on the running sequence.
